// File: rtl/crc32_mem_scan.sv
// CRC-32 memory scanner: walks a word-aligned region over a valid/ready read port, feeds each
// word to crc32_gen (reflected 0xEDB88320, init/xorout all-ones) and checks the final CRC.

module crc32_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_crc,
   input  logic        calc,
   input  logic [31:0] din,
   output logic [31:0] crc
);
   logic [31:0] lfsr;
   logic [31:0] lfsr_next;

   // A word is consumed LSB first, i.e. as four little-endian bytes of standard CRC-32.
   always_comb begin
      lfsr_next = lfsr ^ din;
      for (int unsigned i = 0; i < 32; i++)
         lfsr_next = lfsr_next[0] ? ((lfsr_next >> 1) ^ 32'hEDB8_8320) : (lfsr_next >> 1);
   end

   always_ff @(posedge clk) begin
      if (rst || clr_crc)
         lfsr <= '1;
      else if (calc)
         lfsr <= lfsr_next;
   end

   assign crc = ~lfsr;
endmodule

module crc32_mem_scan #(
   parameter int ADDR_W = 18,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic [31:0]       expected_crc,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [31:0]       crc_out,
   output logic              crc_match,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ, S_GAP, S_FINISH} state_t;

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [31:0]      exp_crc;
   logic             abort_pend;
   logic             clr_crc;
   logic             calc;
   logic [31:0]      crc;

   assign clr_crc = (state == S_CLEAR);
   assign calc    = (state == S_READ) && mem_ready;

   crc32_gen u_crc (
      .clk     (clk),
      .rst     (rst),
      .clr_crc (clr_crc),
      .calc    (calc),
      .din     (mem_rdata),
      .crc     (crc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         remaining  <= '0;
         exp_crc    <= '0;
         abort_pend <= 1'b0;
         crc_out    <= '0;
         crc_match  <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         if (state != S_IDLE)
            abort_pend <= abort_pend | abort;
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  mem_addr   <= base_addr & ~ADDR_W'(3);
                  remaining  <= word_count;
                  exp_crc    <= expected_crc;
                  abort_pend <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_CLEAR;
               end
            end
            S_CLEAR, S_GAP: begin
               // Abort is only honoured here, where no read handshake is in flight.
               if (abort || abort_pend) begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  aborted    <= 1'b1;
                  abort_pend <= 1'b0;
               end else if (remaining == '0) begin
                  state <= S_FINISH;
               end else begin
                  state     <= S_READ;
                  mem_valid <= 1'b1;
               end
            end
            S_READ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  mem_addr  <= mem_addr + ADDR_W'(4);
                  remaining <= remaining - CNT_W'(1);
                  state     <= S_GAP;
               end
            end
            S_FINISH: begin
               crc_out    <= crc;
               crc_match  <= (crc == exp_crc);
               done       <= 1'b1;
               busy       <= 1'b0;
               abort_pend <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_crc32_mem_scan.sv
// Directed/randomized bench for crc32_mem_scan against a byte-wise CRC-32 reference model.

module tb_crc32_mem_scan;
   localparam int ADDR_W = 18;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic [31:0]       expected_crc;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [31:0]       crc_out;
   logic              crc_match;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   crc32_mem_scan #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .base_addr    (base_addr),
      .word_count   (word_count),
      .expected_crc (expected_crc),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .crc_out      (crc_out),
      .crc_match    (crc_match),
      .mem_valid    (mem_valid),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory responder: word array, per-request wait states, handshake log.
   logic [31:0]       mem [0:65535];
   int unsigned       waited = 0;
   int unsigned       cur_delay = 0;
   int unsigned       hs_n = 0;
   int unsigned       delay_max = 0;
   int unsigned       stall_at = 32'hFFFF_FFFF;
   int unsigned       calc_n = 0;
   int unsigned       addr_err = 0;
   logic [ADDR_W-1:0] addr_q [$];
   logic              prev_wait = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;

   assign mem_rdata = mem[mem_addr[ADDR_W-1:2]];
   assign mem_ready = mem_valid && (waited >= cur_delay);

   function automatic int unsigned pick_delay(input int unsigned n);
      if (n == stall_at) return 5;
      if (delay_max == 0) return 0;
      return $urandom_range(0, delay_max);
   endfunction

   always @(posedge clk) begin
      if (mem_valid) begin
         if (mem_ready) begin
            addr_q.push_back(mem_addr);
            waited    <= 0;
            cur_delay <= pick_delay(hs_n + 2);
            hs_n      <= hs_n + 1;
         end else begin
            waited <= waited + 1;
         end
      end
      if (dut.calc) calc_n++;
      if (prev_wait && (!mem_valid || mem_addr !== prev_addr)) addr_err++;
      prev_wait <= mem_valid && !mem_ready && !rst;
      prev_addr <= mem_addr;
   end

   int          n_assert = 0;
   int          n_fail = 0;
   int unsigned scan_hs0, scan_calc0, scan_q0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: standard CRC-32 over the region's bytes in little-endian order.
   function automatic logic [31:0] model_crc(input logic [ADDR_W-1:0] base, input int unsigned n);
      logic [31:0]       c = '1;
      logic [ADDR_W-1:0] a = base & ~ADDR_W'(3);
      for (int unsigned w = 0; w < n; w++) begin
         logic [31:0] word = mem[a[ADDR_W-1:2]];
         for (int b = 0; b < 4; b++) begin
            c = c ^ {24'b0, word[8*b +: 8]};
            for (int k = 0; k < 8; k++)
               c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
         a = a + ADDR_W'(4);
      end
      return ~c;
   endfunction

   task automatic check_addrs(input string tag, input logic [ADDR_W-1:0] base, input int unsigned n);
      logic [ADDR_W-1:0] a = base & ~ADDR_W'(3);
      chk({tag, "_reads"}, 32'(addr_q.size() - scan_q0), 32'(n));
      chk({tag, "_calcs"}, 32'(calc_n - scan_calc0), 32'(n));
      for (int unsigned i = 0; i < n && scan_q0 + i < addr_q.size(); i++) begin
         chk({tag, "_addr"}, 32'(addr_q[scan_q0 + i]), 32'(a));
         a = a + ADDR_W'(4);
      end
   endtask

   task automatic do_scan(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                          input logic [31:0] exp, input int inj_cyc, input int abort_hs,
                          output int bcyc, output bit got_done, output bit got_abort);
      int k = 0;
      bit armed = (abort_hs >= 0);
      scan_hs0   = hs_n;
      scan_calc0 = calc_n;
      scan_q0    = addr_q.size();
      stall_at   = armed ? hs_n + 3 : 32'hFFFF_FFFF;
      base_addr    = base;
      word_count   = cnt;
      expected_crc = exp;
      start        = 1'b1;
      bcyc = 0; got_done = 1'b0; got_abort = 1'b0;
      while (!got_done && !got_abort && k < 400) begin
         @(posedge clk); #1;
         k++;
         start = 1'b0;
         abort = 1'b0;
         if (busy) bcyc++;
         if (done) got_done = 1'b1;
         if (aborted) got_abort = 1'b1;
         if (k == inj_cyc) begin
            start        = 1'b1;
            base_addr    = ADDR_W'($urandom());
            word_count   = CNT_W'($urandom_range(1, 3));
            expected_crc = $urandom();
         end
         if (armed && mem_valid && !mem_ready && int'(hs_n - scan_hs0) == abort_hs) begin
            abort = 1'b1;
            armed = 1'b0;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      chk("scan_terminates", 32'(got_done || got_abort), 32'd1);
   endtask

   initial begin
      int          bc;
      bit          gd, ga;
      logic [31:0] m2, m5;

      for (int i = 0; i < 65536; i++) mem[i] = $urandom();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      base_addr = '0; word_count = '0; expected_crc = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_aborted", 32'(aborted), 0);
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_crc_match", 32'(crc_match), 0);
      chk("rst_crc_out", crc_out, 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      @(posedge clk); #1;

      // Zero-length scan
      do_scan(18'h0, 16'd0, 32'h0, -1, -1, bc, gd, ga);
      chk("zero_done", 32'(gd), 1);
      chk("zero_busy_cycles", 32'(bc), 2);
      chk("zero_reads", 32'(addr_q.size() - scan_q0), 0);
      chk("zero_crc_out", crc_out, 32'h0);
      chk("zero_crc_match", 32'(crc_match), 1);

      // Four words, zero-wait memory
      mem[18'h100 >> 2] = 32'h1111_1111;
      mem[18'h104 >> 2] = 32'h2222_2222;
      mem[18'h108 >> 2] = 32'h3333_3333;
      mem[18'h10C >> 2] = 32'h4444_4444;
      m2 = model_crc(18'h100, 4);
      do_scan(18'h100, 16'd4, 32'h0, -1, -1, bc, gd, ga);
      chk("w4_done", 32'(gd), 1);
      chk("w4_busy_cycles", 32'(bc), 10);
      check_addrs("w4", 18'h100, 4);
      chk("w4_crc_out", crc_out, m2);
      chk("w4_crc_match", 32'(crc_match), 32'(m2 == 32'h0));

      // Random wait states plus an ignored mid-scan start
      delay_max = 5;
      do_scan(18'h100, 16'd4, 32'h0, 3, -1, bc, gd, ga);
      chk("wait_done", 32'(gd), 1);
      check_addrs("wait", 18'h100, 4);
      chk("wait_crc_out", crc_out, m2);
      chk("wait_addr_stable_errs", addr_err, 0);

      // Compare against expected value
      do_scan(18'h100, 16'd4, m2, -1, -1, bc, gd, ga);
      chk("exp_hit_match", 32'(crc_match), 1);
      do_scan(18'h100, 16'd4, m2 ^ 32'h1, -1, -1, bc, gd, ga);
      chk("exp_miss_match", 32'(crc_match), 0);
      chk("exp_miss_crc_out", crc_out, m2);

      // Address wrap and unaligned base
      do_scan(18'h3FFFC, 16'd2, 32'h0, -1, -1, bc, gd, ga);
      check_addrs("wrap", 18'h3FFFC, 2);
      chk("wrap_crc_out", crc_out, model_crc(18'h3FFFC, 2));
      m5 = model_crc(18'h103, 1);
      do_scan(18'h103, 16'd1, m5, -1, -1, bc, gd, ga);
      check_addrs("unaligned", 18'h100, 1);
      chk("unaligned_crc_out", crc_out, m5);
      chk("unaligned_crc_match", 32'(crc_match), 1);

      // Abort during the third read wait
      delay_max = 0;
      do_scan(18'h200, 16'd8, 32'h0, -1, 2, bc, gd, ga);
      chk("abort_pulse", 32'(ga), 1);
      chk("abort_no_done", 32'(gd), 0);
      chk("abort_reads", 32'(addr_q.size() - scan_q0), 3);
      chk("abort_calcs", 32'(calc_n - scan_calc0), 3);
      chk("abort_crc_out_kept", crc_out, m5);
      chk("abort_crc_match_kept", 32'(crc_match), 1);

      // start together with abort in idle
      start = 1'b1; abort = 1'b1; word_count = 16'd4;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", 32'(busy), 0);
      @(posedge clk); #1;
      chk("start_abort_mem_valid", 32'(mem_valid), 0);

      // Reset mid-scan
      base_addr = 18'h400; word_count = 16'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_mem_valid", 32'(mem_valid), 0);
      chk("midrst_crc_out", crc_out, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_done", 32'(done), 0);
      chk("midrst_no_abort", 32'(aborted), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
